framebuffer_write_coalescer: RTL
================================

// Module: framebuffer_write_coalescer
// PURPOSE
//  Sits directly downstream of the sprite engine, between its 4-bit pixel write port and the 16-bit frame buffer RAM.
//  Merges pixel writes into 4-pixel words and commits each word with a single write when all 4 nibbles are known.
//  Otherwise it does a read-modify-write. Absorbs the sprite engine's held write strobe, which has no backpressure.
// PARAMETERS
//  READ_LATENCY  1       cycles from mem_read_enable_out to valid mem_read_data_in (1..3)
//  FIFO_DEPTH    4       input pixel FIFO entries (power of 2)
//  FB_PIXELS     256000  640x400; pixel addresses >= FB_PIXELS are dropped
// PORTS
//  clock_in                 in   1   system clock
//  reset_in                 in   1   synchronous, active-high reset
//  enable_in                in   1   low = flush pending word, then idle
//  flush_in                 in   1   1-cycle pulse: commit pending word
//  pixel_write_enable_in    in   1   level; one pixel captured every cycle it is high
//  pixel_write_address_in   in   18  linear pixel address (x + y*640)
//  pixel_write_data_in      in   4   palette index
//  mem_address_out          out  16  word address = pixel address[17:2]
//  mem_read_enable_out      out  1   1-cycle read strobe
//  mem_read_data_in         in   16  read word
//  mem_write_enable_out     out  1   1-cycle write strobe
//  mem_write_data_out       out  16  nibble i = bits [4i+3:4i] = pixel addr[1:0]==i
//  busy_out                 out  1   FIFO non-empty or word pending or RMW in flight
//  overflow_out             out  1   sticky: a pixel was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0, FIFO emptied, pending mask cleared, state IDLE. Reset mid-RMW aborts it with no write.
//  Capture: every cycle with enable_in & pixel_write_enable_in pushes {addr,data} to the FIFO.
//   Repeated identical pushes are harmless because a later same-nibble write overwrites.
//   FIFO full on a push: the pixel is dropped and overflow_out is set to 1.
//  Pending word: word_addr[15:0], data[15:0], mask[3:0]. The FIFO pops one entry per cycle, only in IDLE/COLLECT.
//  States:
//   IDLE: pop -> load word_addr, set nibble and its mask bit -> COLLECT.
//   COLLECT: pop with the same word_addr -> merge. Pop with a different word_addr -> close the word; the popped pixel is held.
//            flush_in, or enable_in low with FIFO empty -> close the word.
//   Close with mask==4'hF -> WRITE. Any other mask -> READ.
//   READ: mem_read_enable_out=1 for 1 cycle -> READ_WAIT.
//   READ_WAIT: count READ_LATENCY cycles, then merge = (mask ? pending : mem_read_data_in) per nibble -> WRITE.
//   WRITE: mem_write_enable_out=1 for 1 cycle with mem_address_out=word_addr.
//          Then clear the mask. A held pixel starts a new word (COLLECT); otherwise -> IDLE.
//  Latency: full-word write asserts 1 cycle after close. RMW write asserts READ_LATENCY+2 cycles after close.
//  Out-of-range pixel (addr >= FB_PIXELS): discarded at pop; no state change, no overflow.
//  flush_in in the same cycle as a push: the pushed pixel is not part of this flush; it is queued behind it.
//  flush_in with mask==0 or while in READ/READ_WAIT/WRITE: ignored.
//  Arithmetic: nibble index = addr[1:0]; all merges are bitwise 4-bit lane selects.
//  mem_address_out is held stable from READ through WRITE.
// STRUCTURE
//  graphics_pkg: FB_WIDTH=640, FB_PIXELS, PIXELS_PER_WORD=4, coalescer state enum.
//  Sub-module pixel_write_fifo: synchronous FIFO, 22-bit entries, full/empty flags.
//   It has no internal overflow logic; the parent sets overflow_out.
// TESTING
//  Writes to addresses 0..3, data 1,2,3,4, strobe 1 cycle each, then a flush pulse
//   -> exactly one write: address 0, data 16'h4321, no read.
//  Single write to address 5, data 7, then flush, with memory word 1 = 16'hAAAA
//   -> read of word 1, then a write of 16'hAA7A to word 1.
//  Sprite-engine cadence: strobe held 2 cycles per pixel over addresses 8..11, data F,0,F,0
//   -> one write of 16'h0F0F to word 2; overflow_out stays 0.
//  Pixel at address 3 then address 4, then flush
//   -> RMW on word 0 (nibble 3 replaced), then RMW on word 1 (nibble 0 replaced); order preserved.
//  Stall the path with READ_LATENCY=3 while pushing 6 distinct pixels back to back
//   -> first 4 buffered, 5th and 6th dropped, overflow_out=1 until reset_in.
//  reset_in asserted during READ_WAIT
//   -> no mem_write_enable_out pulse; all outputs 0 the next cycle; busy_out=0.

Source files
------------

// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
// graphics_pkg : frame-buffer geometry, coalescer states, nibble lane helpers
// Rev 1.0
// ============================================================================
package graphics_pkg;

    localparam int FB_WIDTH        = 640;
    localparam int FB_PIXELS       = 256000;
    localparam int PIXELS_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_WRITE     = 3'd4
    } coal_state_t;

    function automatic logic [15:0] put_nibble(input logic [15:0] word,
                                               input logic [1:0]  lane,
                                               input logic [3:0]  nib);
        logic [15:0] r;
        r = word;
        r[{lane, 2'b00} +: 4] = nib;
        return r;
    endfunction

    // Lanes with their mask bit set keep the pending pixel, the rest come from RAM.
    function automatic logic [15:0] merge_lanes(input logic [3:0]  mask,
                                                input logic [15:0] pending,
                                                input logic [15:0] mem);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = mask[i] ? pending[i*4 +: 4] : mem[i*4 +: 4];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_write_fifo.sv
`default_nettype none
// ============================================================================
// pixel_write_fifo : synchronous FIFO for {address,data} pixel writes
// Rev 1.0
// ============================================================================
module pixel_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] pop_data_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_one = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_out    = (wr_ptr_q == rd_ptr_q);
    assign full_out     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_push       = push_in && !full_out;
    assign w_pop        = pop_in && !empty_out;
    assign pop_data_out = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_one;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_one;
        end
    end

    always_ff @(posedge clock_in) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_in;
    end

endmodule
`default_nettype wire

// File: rtl/framebuffer_write_coalescer.sv
`default_nettype none
// ============================================================================
// framebuffer_write_coalescer : merges 4-bit pixel writes into 16-bit RAM words
// Rev 1.0
// ============================================================================
module framebuffer_write_coalescer
    import graphics_pkg::coal_state_t, graphics_pkg::ST_IDLE, graphics_pkg::ST_COLLECT,
           graphics_pkg::ST_READ, graphics_pkg::ST_READ_WAIT, graphics_pkg::ST_WRITE,
           graphics_pkg::put_nibble, graphics_pkg::merge_lanes;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int FB_PIXELS    = graphics_pkg::FB_PIXELS
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic        flush_in,
    input  logic        pixel_write_enable_in,
    input  logic [17:0] pixel_write_address_in,
    input  logic [3:0]  pixel_write_data_in,
    output logic [15:0] mem_address_out,
    output logic        mem_read_enable_out,
    input  logic [15:0] mem_read_data_in,
    output logic        mem_write_enable_out,
    output logic [15:0] mem_write_data_out,
    output logic        busy_out,
    output logic        overflow_out
);

    localparam logic [1:0]  c_rl       = 2'(READ_LATENCY);
    localparam logic [18:0] c_fb_limit = 19'(FB_PIXELS);

    coal_state_t state_q;
    logic [15:0] word_addr_q;
    logic [15:0] data_q;
    logic [3:0]  mask_q;
    logic [1:0]  cnt_q;
    logic        hold_valid_q;
    logic [17:0] hold_addr_q;
    logic [3:0]  hold_data_q;
    logic [15:0] mem_addr_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [15:0] mem_wdata_q;
    logic        overflow_q;

    logic        w_push_req;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_pop;
    logic [21:0] w_head;
    logic [17:0] w_head_addr;
    logic [3:0]  w_head_data;
    logic        w_head_ok;
    logic        w_same_word;
    logic [3:0]  w_head_bit;
    logic [15:0] w_col_data;
    logic [3:0]  w_col_mask;
    logic        w_hold_take;
    logic        w_close;

    assign w_push_req = enable_in && pixel_write_enable_in;

    pixel_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (22)
    ) u_fifo (
        .clock_in     (clock_in),
        .reset_in     (reset_in),
        .push_in      (w_push_req),
        .push_data_in ({pixel_write_address_in, pixel_write_data_in}),
        .pop_in       (w_pop),
        .pop_data_out (w_head),
        .full_out     (w_fifo_full),
        .empty_out    (w_fifo_empty)
    );

    assign w_head_addr = w_head[21:4];
    assign w_head_data = w_head[3:0];
    assign w_head_ok   = !w_fifo_empty && ({1'b0, w_head_addr} < c_fb_limit);
    assign w_same_word = (w_head_addr[17:2] == word_addr_q);
    assign w_head_bit  = 4'b0001 << w_head_addr[1:0];

    // Out-of-range heads are popped too, which is how they get discarded.
    assign w_pop = !w_fifo_empty && (state_q == ST_IDLE || state_q == ST_COLLECT);

    always_comb begin
        w_col_data  = data_q;
        w_col_mask  = mask_q;
        w_hold_take = 1'b0;
        if (w_head_ok && w_same_word) begin
            w_col_data = put_nibble(data_q, w_head_addr[1:0], w_head_data);
            w_col_mask = mask_q | w_head_bit;
        end
        if (w_head_ok && !w_same_word) begin
            w_hold_take = 1'b1;
        end
        w_close = w_hold_take || flush_in || (!enable_in && w_fifo_empty);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            word_addr_q  <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (w_push_req && w_fifo_full) overflow_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (w_head_ok) begin
                        word_addr_q <= w_head_addr[17:2];
                        data_q      <= put_nibble(16'h0000, w_head_addr[1:0], w_head_data);
                        mask_q      <= w_head_bit;
                        state_q     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    data_q <= w_col_data;
                    mask_q <= w_col_mask;
                    if (w_hold_take) begin
                        hold_valid_q <= 1'b1;
                        hold_addr_q  <= w_head_addr;
                        hold_data_q  <= w_head_data;
                    end
                    if (w_close) begin
                        mem_addr_q <= word_addr_q;
                        if (w_col_mask == 4'hF) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= w_col_data;
                            state_q     <= ST_WRITE;
                        end else begin
                            mem_re_q <= 1'b1;
                            state_q  <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    cnt_q   <= 2'd1;
                    state_q <= ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    if (cnt_q == c_rl) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merge_lanes(mask_q, data_q, mem_read_data_in);
                        state_q     <= ST_WRITE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_WRITE: begin
                    if (hold_valid_q) begin
                        word_addr_q  <= hold_addr_q[17:2];
                        data_q       <= put_nibble(16'h0000, hold_addr_q[1:0], hold_data_q);
                        mask_q       <= 4'b0001 << hold_addr_q[1:0];
                        hold_valid_q <= 1'b0;
                        state_q      <= ST_COLLECT;
                    end else begin
                        mask_q  <= 4'h0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_address_out      = mem_addr_q;
    assign mem_read_enable_out  = mem_re_q;
    assign mem_write_enable_out = mem_we_q;
    assign mem_write_data_out   = mem_wdata_q;
    assign overflow_out         = overflow_q;
    assign busy_out             = !w_fifo_empty || (mask_q != 4'h0) ||
                                  (state_q != ST_IDLE) || hold_valid_q;

endmodule
`default_nettype wire
